// File: rtl/multicore_data_memory_if.sv
// Per-core request/acknowledge bundle between load/store units and multicore_data_memory.
// Every field is packed per port: port i occupies slice [i*W +: W].
interface multicore_data_memory_if #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 7
);
  logic [NUM_CORES-1:0]        core_req;
  logic [NUM_CORES-1:0]        core_we;
  logic [NUM_CORES*ADDR_W-1:0] core_addr;
  logic [NUM_CORES*DATA_W-1:0] core_wdata;
  logic [NUM_CORES*DATA_W-1:0] core_rdata;
  logic [NUM_CORES-1:0]        core_ack;

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_rdata, core_ack
  );

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_rdata, core_ack
  );
endinterface

// File: rtl/multicore_data_memory.sv
// Multi-port data memory: one private bank per core plus a round-robin shared bank.
// Self-clears every word after reset before accepting accesses.
module multicore_data_memory #(
  parameter int NUM_CORES    = 4,
  parameter int DATA_W       = 8,
  parameter int PRIV_DEPTH   = 64,
  parameter int SHARED_DEPTH = 64,
  parameter int ADDR_W       = $clog2(PRIV_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  multicore_data_memory_if.slave bus,
  output logic                  ready
);
  localparam int PRIV_W   = ADDR_W - 1;
  localparam int SHR_W    = $clog2(SHARED_DEPTH);
  localparam int INIT_LEN = (PRIV_DEPTH > SHARED_DEPTH) ? PRIV_DEPTH : SHARED_DEPTH;
  localparam int CNT_W    = $clog2(INIT_LEN);
  localparam int PTR_W    = $clog2(NUM_CORES);

  typedef enum logic {INIT, RUN} state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  init_cnt_reg, init_cnt_next;
  logic [PTR_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic              run;
  logic              init_priv;
  logic              init_shr;

  logic [NUM_CORES-1:0] priv_acc;
  logic [NUM_CORES-1:0] shr_req;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_any;
  logic [PTR_W-1:0]     winner;
  logic [PTR_W-1:0]     cand;

  logic [PRIV_W-1:0] priv_idx   [NUM_CORES];
  logic [SHR_W-1:0]  shr_idx    [NUM_CORES];
  logic [DATA_W-1:0] wdata      [NUM_CORES];
  logic [DATA_W-1:0] priv_rd    [NUM_CORES];

  logic [DATA_W-1:0] shr_mem [SHARED_DEPTH];
  logic [SHR_W-1:0]  shr_sel_idx;
  logic [DATA_W-1:0] shr_sel_wdata;
  logic              shr_sel_we;
  logic [DATA_W-1:0] shr_rd;

  assign run       = (state_reg == RUN);
  assign ready     = run;
  // Private banks may be shallower than the init sweep when the shared bank is larger.
  assign init_priv = (32'(init_cnt_reg) < 32'(PRIV_DEPTH));
  assign init_shr  = (32'(init_cnt_reg) < 32'(SHARED_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= INIT;
      init_cnt_reg <= '0;
      rr_ptr_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
      rr_ptr_reg   <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    case (state_reg)
      INIT: begin
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == CNT_W'(INIT_LEN - 1)) begin
          state_next = RUN;
        end
      end
      RUN: state_next = RUN;
      default: state_next = INIT;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_port
      logic [ADDR_W-1:0] addr;
      logic              is_shr;
      logic [DATA_W-1:0] priv_mem [PRIV_DEPTH];
      logic              ack_reg;
      logic [DATA_W-1:0] rdata_reg;

      assign addr         = bus.core_addr[gi*ADDR_W +: ADDR_W];
      assign wdata[gi]    = bus.core_wdata[gi*DATA_W +: DATA_W];
      assign is_shr       = addr[ADDR_W-1];
      assign priv_idx[gi] = addr[PRIV_W-1:0];
      assign shr_idx[gi]  = addr[SHR_W-1:0];
      assign priv_acc[gi] = run & bus.core_req[gi] & ~is_shr;
      assign shr_req[gi]  = run & bus.core_req[gi] & is_shr;

      always_ff @(posedge clk) begin
        if (!run) begin
          if (init_priv) begin
            priv_mem[init_cnt_reg[PRIV_W-1:0]] <= '0;
          end
        end else if (priv_acc[gi] && bus.core_we[gi]) begin
          priv_mem[priv_idx[gi]] <= wdata[gi];
        end
      end

      assign priv_rd[gi] = priv_mem[priv_idx[gi]];

      // rdata only moves on a read; write acks leave the last read value visible.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          ack_reg   <= 1'b0;
          rdata_reg <= '0;
        end else begin
          ack_reg <= priv_acc[gi] | grant[gi];
          if (priv_acc[gi] && !bus.core_we[gi]) begin
            rdata_reg <= priv_rd[gi];
          end else if (grant[gi] && !bus.core_we[gi]) begin
            rdata_reg <= shr_rd;
          end
        end
      end

      assign bus.core_ack[gi]                   = ack_reg;
      assign bus.core_rdata[gi*DATA_W +: DATA_W] = rdata_reg;
    end
  endgenerate

  // Round-robin: first shared requester at or above the pointer, wrapping.
  always_comb begin
    grant       = '0;
    grant_any   = 1'b0;
    winner      = rr_ptr_reg;
    cand        = rr_ptr_reg;
    rr_ptr_next = rr_ptr_reg;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = PTR_W'((int'(rr_ptr_reg) + k) % NUM_CORES);
      if (!grant_any && shr_req[cand]) begin
        grant_any = 1'b1;
        winner    = cand;
      end
    end
    if (grant_any) begin
      grant[winner] = 1'b1;
      rr_ptr_next   = (winner == PTR_W'(NUM_CORES - 1)) ? '0 : winner + 1'b1;
    end
  end

  assign shr_sel_idx   = shr_idx[winner];
  assign shr_sel_wdata = wdata[winner];
  assign shr_sel_we    = bus.core_we[winner];

  always_ff @(posedge clk) begin
    if (!run) begin
      if (init_shr) begin
        shr_mem[init_cnt_reg[SHR_W-1:0]] <= '0;
      end
    end else if (grant_any && shr_sel_we) begin
      shr_mem[shr_sel_idx] <= shr_sel_wdata;
    end
  end

  assign shr_rd = shr_mem[shr_sel_idx];
endmodule

// File: tb/tb_multicore_data_memory.sv
// Randomised and directed bench for multicore_data_memory with a scoreboard fed by
// a bank-level reference model and drained by an independent ack monitor.
module tb_multicore_data_memory;
  localparam int NC       = 4;
  localparam int DW       = 8;
  localparam int PD       = 64;
  localparam int SD       = 64;
  localparam int AW       = 7;
  localparam int INIT_LEN = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ready;

  always #5 clk = ~clk;

  multicore_data_memory_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus();

  multicore_data_memory #(
    .NUM_CORES(NC), .DATA_W(DW), .PRIV_DEPTH(PD), .SHARED_DEPTH(SD), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .ready(ready)
  );

  typedef struct {
    int          port;
    int          cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int edge_cnt = 0;
  int since_rel = 0;
  int rr_ptr = 0;
  bit exp_ready = 1'b0;
  bit pending [NC];

  bit            d_req   [NC];
  bit            d_we    [NC];
  logic [AW-1:0] d_addr  [NC];
  logic [DW-1:0] d_wdata [NC];

  logic [DW-1:0] m_priv  [NC][PD];
  logic [DW-1:0] m_shr   [SD];
  logic [DW-1:0] m_rdata [NC];

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end else begin
      $display("check %s ok value=%0h", name, got);
    end
  endtask

  task automatic model_reset();
    rr_ptr    = 0;
    since_rel = 0;
    exp_ready = 1'b0;
    sb.delete();
    for (int q = 0; q < NC; q++) begin
      pending[q] = 1'b0;
      m_rdata[q] = '0;
      for (int a = 0; a < PD; a++) m_priv[q][a] = '0;
    end
    for (int a = 0; a < SD; a++) m_shr[a] = '0;
  endtask

  // Predicts the outcome of the upcoming clock edge from the currently driven inputs.
  task automatic model_step();
    int   win;
    int   p;
    int   idx;
    exp_t e;
    edge_cnt++;
    if (!reset) begin
      model_reset();
      return;
    end
    since_rel++;
    if (since_rel <= INIT_LEN) begin
      exp_ready = (since_rel == INIT_LEN);
      return;
    end
    exp_ready = 1'b1;
    win = -1;
    for (int k = 0; k < NC; k++) begin
      p = (rr_ptr + k) % NC;
      if (win < 0 && d_req[p] && d_addr[p] >= AW'(PD)) win = p;
    end
    for (int q = 0; q < NC; q++) begin
      pending[q] = 1'b0;
      if (d_req[q]) begin
        if (d_addr[q] < AW'(PD)) begin
          idx = int'(d_addr[q]) % PD;
          if (d_we[q]) m_priv[q][idx] = d_wdata[q];
          else         m_rdata[q] = m_priv[q][idx];
          e.port = q; e.cyc = edge_cnt; e.data = m_rdata[q];
          sb.push_back(e);
        end else if (q == win) begin
          idx = int'(d_addr[q]) % SD;
          if (d_we[q]) m_shr[idx] = d_wdata[q];
          else         m_rdata[q] = m_shr[idx];
          e.port = q; e.cyc = edge_cnt; e.data = m_rdata[q];
          sb.push_back(e);
        end else begin
          pending[q] = 1'b1;
        end
      end
    end
    if (win >= 0) rr_ptr = (win + 1) % NC;
  endtask

  task automatic set_port(int p, bit rq, bit w, int a, int d);
    if (!pending[p]) begin
      d_req[p]   = rq;
      d_we[p]    = w;
      d_addr[p]  = AW'(a);
      d_wdata[p] = DW'(d);
    end
  endtask

  task automatic set_idle();
    for (int q = 0; q < NC; q++) set_port(q, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic tick();
    for (int q = 0; q < NC; q++) begin
      bus.core_req[q]             = d_req[q];
      bus.core_we[q]              = d_we[q];
      bus.core_addr[q*AW +: AW]   = d_addr[q];
      bus.core_wdata[q*DW +: DW]  = d_wdata[q];
    end
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic bit any_pending();
    bit r;
    r = 1'b0;
    for (int q = 0; q < NC; q++) r |= pending[q];
    return r;
  endfunction

  task automatic drain();
    for (int i = 0; i < 20; i++) begin
      set_idle();
      tick();
      if (!any_pending()) break;
    end
    if (any_pending()) begin
      total++;
      bad++;
      $display("FAIL drain pending_left=1 want=0");
    end
    set_idle();
  endtask

  function automatic int rdata_of(int p);
    return int'(bus.core_rdata[p*DW +: DW]);
  endfunction

  // Monitor: every cycle, compare ready and match each ack against the scoreboard.
  initial begin
    int j;
    forever begin
      @(posedge clk);
      #1;
      total++;
      if (ready !== exp_ready) begin
        bad++;
        $display("FAIL ready edge=%0d got=%0b want=%0b", edge_cnt, ready, exp_ready);
      end
      for (int p = 0; p < NC; p++) begin
        j = -1;
        for (int q = 0; q < sb.size(); q++) if (j < 0 && sb[q].port == p) j = q;
        if (j >= 0 && sb[j].cyc <= edge_cnt) begin
          total++;
          if (bus.core_ack[p] !== 1'b1 || sb[j].cyc != edge_cnt) begin
            bad++;
            $display("FAIL ack_missing port=%0d edge=%0d got_ack=%0b want_ack=1 (due edge %0d)",
                     p, edge_cnt, bus.core_ack[p], sb[j].cyc);
          end else if (bus.core_rdata[p*DW +: DW] !== sb[j].data) begin
            bad++;
            $display("FAIL ack_rdata port=%0d edge=%0d got=%02h want=%02h",
                     p, edge_cnt, bus.core_rdata[p*DW +: DW], sb[j].data);
          end else begin
            $display("ack port=%0d edge=%0d rdata=%02h", p, edge_cnt, sb[j].data);
          end
          sb.delete(j);
        end else if (bus.core_ack[p] !== 1'b0) begin
          total++;
          bad++;
          $display("FAIL ack_unexpected port=%0d edge=%0d got_ack=%0b want_ack=0",
                   p, edge_cnt, bus.core_ack[p]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int q = 0; q < NC; q++) begin
      d_req[q] = 1'b0; d_we[q] = 1'b0; d_addr[q] = '0; d_wdata[q] = '0;
      pending[q] = 1'b0;
    end
    bus.core_req = '0; bus.core_we = '0; bus.core_addr = '0; bus.core_wdata = '0;
    model_reset();

    // Reset state
    #1 reset = 1'b0;
    #1;
    chk("rst_ready", int'(ready), 0);
    chk("rst_ack", int'(bus.core_ack), 0);
    chk("rst_rdata", int'(bus.core_rdata), 0);
    @(negedge clk);
    repeat (3) tick();
    reset = 1'b1;

    // INIT: all ports hammer random accesses; none may be acked or take effect
    for (int i = 0; i < INIT_LEN; i++) begin
      for (int q = 0; q < NC; q++)
        set_port(q, 1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 127)), int'($urandom_range(0, 255)));
      tick();
    end
    chk("ready_after_init", int'(ready), 1);

    // Round-robin: all ports hold a shared read from pointer 0
    for (int q = 0; q < NC; q++) set_port(q, 1'b1, 1'b0, 'h40, 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_order", int'(bus.core_ack), 1 << (k % NC));
    end
    drain();

    // Every private and shared word reads back zero
    for (int a = 0; a < PD; a++) begin
      for (int q = 0; q < NC; q++) set_port(q, 1'b1, 1'b0, a, 0);
      tick();
    end
    set_idle();
    for (int a = 0; a < SD; a++) begin
      set_idle();
      set_port(a % NC, 1'b1, 1'b0, PD + a, 0);
      tick();
    end
    drain();

    // Private write/read and bank isolation
    set_port(2, 1'b1, 1'b1, 'h05, 'hA5);
    tick();
    chk("p2_write_ack", int'(bus.core_ack[2]), 1);
    set_port(2, 1'b1, 1'b0, 'h05, 0);
    set_port(0, 1'b1, 1'b0, 'h05, 0);
    tick();
    chk("p2_priv_rdata", rdata_of(2), 'hA5);
    chk("p0_isolated", rdata_of(0), 'h00);
    set_idle();
    tick();

    // Shared write by port 1, read by port 3
    set_port(1, 1'b1, 1'b1, 'h47, 'h3C);
    tick();
    set_idle();
    set_port(3, 1'b1, 1'b0, 'h47, 0);
    tick();
    chk("p3_shared_rdata", rdata_of(3), 'h3C);
    set_idle();
    tick();

    // Private port unaffected by shared contention
    for (int k = 0; k < 10; k++) begin
      set_port(0, 1'b1, 1'b0, int'($urandom_range(0, 63)), 0);
      set_port(1, 1'b1, 1'b0, 'h41, 0);
      set_port(2, 1'b1, 1'b1, 'h42, k);
      tick();
      chk("p0_every_cycle", int'(bus.core_ack[0]), 1);
    end
    drain();

    // Randomised traffic focused on a few words per region
    for (int k = 0; k < 500; k++) begin
      for (int q = 0; q < NC; q++) begin
        int a;
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 7));
        a += int'($urandom_range(0, 1)) * PD;
        set_port(q, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 255)));
      end
      tick();
    end
    drain();

    // Reset while port 2 waits for a shared grant
    for (int q = 0; q < NC; q++) set_port(q, 1'b1, 1'b0, 'h40 + q, 0);
    tick();
    for (int i = 0; i < 4 && !pending[2]; i++) tick();
    #2 reset = 1'b0;
    #1;
    chk("midrst_ack", int'(bus.core_ack), 0);
    chk("midrst_rdata", int'(bus.core_rdata), 0);
    chk("midrst_ready", int'(ready), 0);
    model_reset();
    set_idle();
    @(negedge clk);
    repeat (2) tick();
    reset = 1'b1;
    repeat (INIT_LEN) tick();
    set_port(2, 1'b1, 1'b0, 'h05, 0);
    tick();
    chk("p2_after_reinit", rdata_of(2), 'h00);
    set_idle();
    repeat (2) tick();

    chk("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
